// File: rtl/f2i_seq_if.sv
// f2i_seq_if: handshake bundle for the sequential float-to-int converter.
//   Input side : in_valid, in_ready, a (float operand), p_in (upstream precision-lost)
//   Output side: out_valid, out_ready, d (int32 result), p_lost, invalid
//   modport slave  : the converter
//   modport master : the producer/consumer driving and receiving it
interface f2i_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        p_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        p_lost;
  logic        invalid;

  modport slave (
    input  in_valid, a, p_in, out_ready,
    output in_ready, out_valid, d, p_lost, invalid
  );

  modport master (
    output in_valid, a, p_in, out_ready,
    input  in_ready, out_valid, d, p_lost, invalid
  );
endinterface

// File: rtl/f2i_seq.sv
// f2i_seq: multi-cycle IEEE-754 single -> signed int32 converter using a
// one-bit-per-cycle shifter instead of a barrel shifter.
// Ports:
//   clk  - clock, rising edge
//   clrn - asynchronous active-low reset
//   bus  - f2i_seq_if.slave: in_valid/in_ready/a/p_in accept side,
//          out_valid/out_ready/d/p_lost/invalid result side
// Optional feature macro: F2I_ROUND_NEAREST_EN (round to nearest-even on
// right shifts, adds a ROUND state). Undefined: truncation toward zero.
module f2i_seq (
  input logic      clk,
  input logic      clrn,
  f2i_seq_if.slave bus
);

`ifdef F2I_ROUND_NEAREST_EN
  typedef enum logic [1:0] {StIdle, StShift, StRound, StResult} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StResult} state_e;
`endif

  state_e      r_state, w_state_nxt;
  logic [31:0] r_w, w_w_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic        r_dir, w_dir_nxt;        // 1: left, 0: right
  logic        r_sign, w_sign_nxt;
  logic        r_sticky, w_sticky_nxt;  // every discarded bit plus p_in
  logic [31:0] r_d, w_d_nxt;
  logic        r_p_lost, w_p_lost_nxt;
  logic        r_invalid, w_invalid_nxt;
`ifdef F2I_ROUND_NEAREST_EN
  logic        r_guard, w_guard_nxt;    // last bit shifted out
  logic        r_rstk, w_rstk_nxt;      // bits below guard, for the tie test
  logic [31:0] w_rnd;
`endif

  logic [7:0]  w_exp;
  logic [23:0] w_sig;
  logic [31:0] w_shift;

  function automatic logic [31:0] apply_sign(input logic s, input logic [31:0] v);
    return s ? (~v + 32'd1) : v;
  endfunction

  assign w_exp   = bus.a[30:23];
  assign w_sig   = {(w_exp != 8'd0), bus.a[22:0]};
  assign w_shift = r_dir ? {r_w[30:0], 1'b0} : {1'b0, r_w[31:1]};
`ifdef F2I_ROUND_NEAREST_EN
  assign w_rnd   = r_w + {31'd0, r_guard & (r_rstk | r_w[0])};
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_w_nxt       = r_w;
    w_cnt_nxt     = r_cnt;
    w_dir_nxt     = r_dir;
    w_sign_nxt    = r_sign;
    w_sticky_nxt  = r_sticky;
    w_d_nxt       = r_d;
    w_p_lost_nxt  = r_p_lost;
    w_invalid_nxt = r_invalid;
`ifdef F2I_ROUND_NEAREST_EN
    w_guard_nxt   = r_guard;
    w_rstk_nxt    = r_rstk;
`endif
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_sign_nxt   = bus.a[31];
          w_sticky_nxt = bus.p_in;
`ifdef F2I_ROUND_NEAREST_EN
          w_guard_nxt  = 1'b0;
          w_rstk_nxt   = 1'b0;
`endif
          if (w_exp == 8'hFF || (w_exp >= 8'd158 && bus.a != 32'hCF00_0000)) begin
            // NaN, Inf or magnitude >= 2^31 (except exactly -2^31)
            w_state_nxt   = StResult;
            w_d_nxt       = 32'h8000_0000;
            w_invalid_nxt = 1'b1;
            w_p_lost_nxt  = 1'b0;
          end else if (bus.a == 32'hCF00_0000) begin
            w_state_nxt   = StResult;
            w_d_nxt       = 32'h8000_0000;
            w_invalid_nxt = 1'b0;
            w_p_lost_nxt  = bus.p_in;
          end else if (w_exp < 8'd127) begin
            // |a| < 1: zero, denormals and pure fractions
            w_state_nxt   = StResult;
            w_d_nxt       = 32'd0;
            w_invalid_nxt = 1'b0;
            w_p_lost_nxt  = (bus.a[30:0] != 31'd0) | bus.p_in;
          end else begin
            w_w_nxt       = {8'd0, w_sig};
            w_invalid_nxt = 1'b0;
            // 150 = 127 + 23; modulo-32 arithmetic is exact for 0..23
            if (w_exp >= 8'd150) begin
              w_dir_nxt = 1'b1;
              w_cnt_nxt = w_exp[4:0] - 5'd22;
            end else begin
              w_dir_nxt = 1'b0;
              w_cnt_nxt = 5'd22 - w_exp[4:0];
            end
            if (w_exp == 8'd150) begin
              w_state_nxt  = StResult;
              w_d_nxt      = apply_sign(bus.a[31], {8'd0, w_sig});
              w_p_lost_nxt = bus.p_in;
            end else begin
              w_state_nxt = StShift;
            end
          end
        end
      end
      StShift: begin
        w_w_nxt      = w_shift;
        w_cnt_nxt    = r_cnt - 5'd1;
        w_sticky_nxt = r_sticky | (~r_dir & r_w[0]);
`ifdef F2I_ROUND_NEAREST_EN
        if (!r_dir) begin
          w_guard_nxt = r_w[0];
          w_rstk_nxt  = r_rstk | r_guard;
        end
`endif
        if (r_cnt == 5'd1) begin
`ifdef F2I_ROUND_NEAREST_EN
          if (!r_dir) begin
            w_state_nxt = StRound;
          end else begin
            w_state_nxt  = StResult;
            w_d_nxt      = apply_sign(r_sign, w_shift);
            w_p_lost_nxt = w_sticky_nxt;
          end
`else
          w_state_nxt  = StResult;
          w_d_nxt      = apply_sign(r_sign, w_shift);
          w_p_lost_nxt = w_sticky_nxt;
`endif
        end
      end
`ifdef F2I_ROUND_NEAREST_EN
      StRound: begin
        w_state_nxt  = StResult;
        w_p_lost_nxt = r_sticky;
        if (!r_sign && w_rnd[31]) begin
          w_d_nxt       = 32'h8000_0000;
          w_invalid_nxt = 1'b1;
        end else begin
          w_d_nxt = apply_sign(r_sign, w_rnd);
        end
      end
`endif
      StResult: begin
        if (bus.out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state   <= StIdle;
      r_w       <= 32'd0;
      r_cnt     <= 5'd0;
      r_dir     <= 1'b0;
      r_sign    <= 1'b0;
      r_sticky  <= 1'b0;
      r_d       <= 32'd0;
      r_p_lost  <= 1'b0;
      r_invalid <= 1'b0;
`ifdef F2I_ROUND_NEAREST_EN
      r_guard   <= 1'b0;
      r_rstk    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_w       <= w_w_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_sign    <= w_sign_nxt;
      r_sticky  <= w_sticky_nxt;
      r_d       <= w_d_nxt;
      r_p_lost  <= w_p_lost_nxt;
      r_invalid <= w_invalid_nxt;
`ifdef F2I_ROUND_NEAREST_EN
      r_guard   <= w_guard_nxt;
      r_rstk    <= w_rstk_nxt;
`endif
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StResult);
  assign bus.d         = r_d;
  assign bus.p_lost    = r_p_lost;
  assign bus.invalid   = r_invalid;

endmodule

// File: tb/tb_f2i_seq.sv
// tb_f2i_seq: directed-vector bench for f2i_seq with a scoreboard queue.
// The driver pushes hand-computed expectations; an independent monitor pops
// and compares on each rising out_valid, and checks hold stability.
module tb_f2i_seq;
  logic clk;
  logic clrn;
  f2i_seq_if bus ();

  f2i_seq dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

`ifdef F2I_ROUND_NEAREST_EN
  localparam int          RndLat = 1;
  localparam logic [31:0] DOnePointFive = 32'd2;
`else
  localparam int          RndLat = 0;
  localparam logic [31:0] DOnePointFive = 32'd1;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        pl;
    logic        inv;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_d;
  logic        held_pl, held_inv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!clrn) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc + 1;
      if (bus.out_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected out_valid", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk($sformatf("d a=%h", e.a), bus.d, e.d);
          chk($sformatf("p_lost a=%h", e.a), {31'd0, bus.p_lost}, {31'd0, e.pl});
          chk($sformatf("invalid a=%h", e.a), {31'd0, bus.invalid}, {31'd0, e.inv});
          chk($sformatf("latency a=%h", e.a), 32'(cyc - acc_cyc + 1), 32'(e.lat));
        end
        held_d   = bus.d;
        held_pl  = bus.p_lost;
        held_inv = bus.invalid;
      end else if (bus.out_valid && prev_valid) begin
        chk("hold d", bus.d, held_d);
        chk("hold flags", {30'd0, bus.p_lost, bus.invalid}, {30'd0, held_pl, held_inv});
        chk("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      prev_valid <= bus.out_valid;
    end
  end

  task automatic run(input logic [31:0] av, input logic pin, input logic [31:0] ed,
                     input logic epl, input logic einv, input int elat, input int hold);
    int t;
    sb_q.push_back('{av, ed, epl, einv, elat});
    @(posedge clk); #1;
    bus.a = av; bus.p_in = pin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = 32'hDEAD_BEEF; bus.p_in = 1'b1;
    t = 0;
    while (!bus.out_valid && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.out_valid) begin
      chk($sformatf("out_valid timeout a=%h", av), {31'd0, bus.out_valid}, 32'd1);
      sb_q.delete();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i < 3);
      bus.a = 32'h3F80_0000;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("released", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  initial begin
    clrn = 1'b0;
    bus.in_valid = 1'b0; bus.a = 32'd0; bus.p_in = 1'b0; bus.out_ready = 1'b0;
    #3;
    chk("reset in_ready/out_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    chk("reset d", bus.d, 32'd0);
    chk("reset flags", {30'd0, bus.p_lost, bus.invalid}, 32'd0);
    #9 clrn = 1'b1;

    //  a             p_in  d              pl    inv   latency        hold
    run(32'h3F80_0000, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 24 + RndLat, 0); // 1.0
    run(32'h4EFF_FFFF, 1'b0, 32'h7FFF_FF80, 1'b0, 1'b0, 8,           0);
    run(32'hCF00_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1,           0); // -2^31
    run(32'h4F00_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1,           0); // 2^31
    run(32'h7FC0_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1,           0); // NaN
    run(32'hFF80_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1,           0); // -Inf
    run(32'h3FC0_0000, 1'b0, DOnePointFive, 1'b1, 1'b0, 24 + RndLat, 0); // 1.5
    run(32'hBF00_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1,           0); // -0.5
    run(32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1,           0); // +0
    run(32'h4B00_0000, 1'b0, 32'h0080_0000, 1'b0, 1'b0, 1,           0); // 2^23, no shift
    run(32'hC040_0000, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0, 23 + RndLat, 0); // -3.0
    run(32'hC020_0000, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 23 + RndLat, 0); // -2.5 (tie to even)
    run(32'h4000_0000, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 23 + RndLat, 0); // 2.0, p_in set
    run(32'hCEFF_FFFF, 1'b0, 32'h8000_0080, 1'b0, 1'b0, 8,           5); // held result

    // Reset in the middle of SHIFT discards the pending 1.0.
    @(posedge clk); #1;
    bus.a = 32'h3F80_0000; bus.p_in = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 clrn = 1'b0;
    #1;
    chk("mid reset in_ready/out_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    chk("mid reset d", bus.d, 32'd0);
    @(posedge clk); #1 clrn = 1'b1;
    run(32'h4040_0000, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 23 + RndLat, 0); // 3.0

    repeat (30) @(posedge clk);
    chk("no stray results", {31'd0, bus.out_valid}, 32'd0);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
